bram_port_master: RTL and testbench

- Initiator for one port of a true-dual-port read-first block RAM with 1-cycle read latency.
- Accepts read/write requests on a valid/ready channel and drives the RAM port pins (en, we, addr, di).
- Captures read data one cycle after issue into a response FIFO and returns it on a valid/ready response channel, in request order.
- Credit-based issue, so response backpressure never loses RAM data. Sits between a DMA/compute engine and one RAM port.

---
 rtl/bram_port_master.sv | 118 +++++++++++
 tb/tb_bram_port_master.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_master.sv
// bram_port_master: initiator for one port of a read-first block RAM with
// 1-cycle read latency. Requests pass straight through to the RAM pins; read
// data is captured one cycle after issue into a small circular response FIFO.
// Issue is credit-gated so that every in-flight read always has a FIFO slot.
// Optional feature: define BRAM_PORT_MASTER_WRBACK_EN to make every accepted
// write also return the pre-write (read-first) word as a response.
module bram_port_master #(
   parameter int SIZE      = 1024,
   parameter int WIDTH     = 256,
   parameter int RSP_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_we,
   input  logic [$clog2(SIZE)-1:0] req_addr,
   input  logic [WIDTH-1:0]        req_wdata,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [WIDTH-1:0]        rsp_rdata,
   output logic                    ram_en,
   output logic                    ram_we,
   output logic [$clog2(SIZE)-1:0] ram_addr,
   output logic [WIDTH-1:0]        ram_di,
   input  logic [WIDTH-1:0]        ram_do
);

   localparam int PW  = $clog2(RSP_DEPTH);
   localparam int CW  = $clog2(RSP_DEPTH + 1);
   localparam int CW1 = CW + 1;

   logic             rd_pending_q, rd_pending_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] mem_q [RSP_DEPTH];
   logic [WIDTH-1:0] mem_d [RSP_DEPTH];

   logic             push;
   logic             pop;
   logic             captures;
   logic [CW:0]      occ;
   logic [CW:0]      occ_after_pop;

   // Circular pointer advance; depth need not be a power of two.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Credit check, RAM pin pass-through and response head presentation.
   always_comb begin
      rsp_valid     = (count_q != '0);
      pop           = rsp_valid & rsp_ready;
      push          = rd_pending_q;
      occ           = {1'b0, count_q} + {{CW{1'b0}}, rd_pending_q};
      // A slot freed by this cycle's pop may be reused by this cycle's issue.
      occ_after_pop = occ - {{CW{1'b0}}, pop};
      req_ready     = rst_n & (occ_after_pop < CW1'(RSP_DEPTH));
      ram_en        = req_valid & req_ready;
      ram_we        = req_we & ram_en;
      ram_addr      = req_addr;
      ram_di        = req_wdata;
`ifdef BRAM_PORT_MASTER_WRBACK_EN
      captures      = ram_en;
`else
      captures      = ram_en & ~req_we;
`endif
      // Gated so the output reads zero whenever nothing is buffered.
      rsp_rdata     = rsp_valid ? mem_q[rd_ptr_q] : '0;
   end

   // FIFO next state: unconditional capture of ram_do the cycle after issue.
   always_comb begin
      rd_pending_d = captures;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      mem_d        = mem_q;
      if (push) begin
         mem_d[wr_ptr_q] = ram_do;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state; reset discards any in-flight read and buffered data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_pending_q <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
      end else begin
         rd_pending_q <= rd_pending_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
      end
   end

   // FIFO storage; contents are only observable through a valid head.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   // Credit gating must make a push into a full FIFO impossible.
   fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && !pop && (count_q == CW'(RSP_DEPTH))));

endmodule

// File: tb/tb_bram_port_master.sv
// Testbench for bram_port_master: two instances (RSP_DEPTH 4 and 3) share the
// request inputs and rsp_ready, each with its own read-first RAM model.
`timescale 1ns/1ps
module tb_bram_port_master;

   localparam int SIZE  = 64;
   localparam int WIDTH = 32;
   localparam int AW    = $clog2(SIZE);

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             req_valid = 1'b0;
   logic             req_we = 1'b0;
   logic             rsp_ready = 1'b0;
   logic [AW-1:0]    req_addr = '0;
   logic [WIDTH-1:0] req_wdata = '0;
   logic             do_preload = 1'b0;

   logic             req_ready [2];
   logic             rsp_valid [2];
   logic             ram_en    [2];
   logic             ram_we    [2];
   logic [WIDTH-1:0] rsp_rdata [2];
   logic [WIDTH-1:0] ram_di    [2];
   logic [WIDTH-1:0] ram_do    [2];
   logic [AW-1:0]    ram_addr  [2];

   logic [WIDTH-1:0] ram    [2][SIZE];
   logic [WIDTH-1:0] ref_m  [2][SIZE];
   logic [WIDTH-1:0] exp_q  [2][$];
   logic [WIDTH-1:0] act_q  [2][$];
   logic [WIDTH-1:0] expd_q [2][$];
   int               unexp  [2];

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   bram_port_master #(.SIZE(SIZE), .WIDTH(WIDTH), .RSP_DEPTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready[0]), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata[0]),
      .ram_en(ram_en[0]), .ram_we(ram_we[0]), .ram_addr(ram_addr[0]),
      .ram_di(ram_di[0]), .ram_do(ram_do[0])
   );

   bram_port_master #(.SIZE(SIZE), .WIDTH(WIDTH), .RSP_DEPTH(3)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready[1]), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata[1]),
      .ram_en(ram_en[1]), .ram_we(ram_we[1]), .ram_addr(ram_addr[1]),
      .ram_di(ram_di[1]), .ram_do(ram_do[1])
   );

   // Read-first RAM ports with 1-cycle read latency; preload fills data = addr.
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (do_preload) begin
            for (int i = 0; i < SIZE; i++) ram[d][i] <= WIDTH'(i);
         end else if (ram_en[d]) begin
            ram_do[d] <= ram[d][ram_addr[d]];
            if (ram_we[d]) ram[d][ram_addr[d]] <= ram_di[d];
         end
      end
   end

   // Reference model: memory image plus an ordered queue of owed responses.
   initial begin
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (do_preload) begin
               for (int i = 0; i < SIZE; i++) ref_m[d][i] = WIDTH'(i);
               exp_q[d].delete();
               act_q[d].delete();
               expd_q[d].delete();
               unexp[d] = 0;
            end else if (!rst_n) begin
               exp_q[d].delete();
            end else begin
               if (rsp_valid[d] && rsp_ready) begin
                  act_q[d].push_back(rsp_rdata[d]);
                  if (exp_q[d].size() > 0) expd_q[d].push_back(exp_q[d].pop_front());
                  else unexp[d] = unexp[d] + 1;
               end
               if (req_valid && req_ready[d]) begin
                  if (!req_we) begin
                     exp_q[d].push_back(ref_m[d][req_addr]);
                  end else begin
`ifdef BRAM_PORT_MASTER_WRBACK_EN
                     exp_q[d].push_back(ref_m[d][req_addr]);
`endif
                     ref_m[d][req_addr] = req_wdata;
                  end
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload();
      req_valid  = 1'b0;
      do_preload = 1'b1;
      @(negedge clk);
      tick();
      do_preload = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      rst_n = 1'b0;
      req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(3); rsp_ready = 1'b1;
      #2;
      checks++; if (req_ready[0] !== 1'b0) begin failures++; $display("FAIL rst_req_ready got=%0b want=0", req_ready[0]); end
      checks++; if (req_ready[1] !== 1'b0) begin failures++; $display("FAIL rst_req_ready3 got=%0b want=0", req_ready[1]); end
      checks++; if (rsp_valid[0] !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got=%0b want=0", rsp_valid[0]); end
      checks++; if (ram_en[0] !== 1'b0) begin failures++; $display("FAIL rst_ram_en got=%0b want=0", ram_en[0]); end
      repeat (3) @(posedge clk);
      #1;
      req_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (req_ready[0] !== 1'b1) begin failures++; $display("FAIL post_rst_req_ready got=%0b want=1", req_ready[0]); end
      checks++; if (rsp_valid[0] !== 1'b0) begin failures++; $display("FAIL post_rst_rsp_valid got=%0b want=0", rsp_valid[0]); end
      checks++; if (rsp_rdata[0] !== '0) begin failures++; $display("FAIL post_rst_rsp_rdata got=%0h want=0", rsp_rdata[0]); end
      tick();
   endtask

   task automatic test_read_after_write();
      int  en_cnt;
      logic want_v;
      preload();
      rsp_ready = 1'b1;
      en_cnt = 0;
      req_valid = 1'b1; req_we = 1'b1; req_addr = AW'(5); req_wdata = 32'hA5A5;
      @(negedge clk);
      if (ram_en[0]) en_cnt++;
      checks++; if (ram_we[0] !== 1'b1) begin failures++; $display("FAIL raw_ram_we got=%0b want=1", ram_we[0]); end
      checks++; if (ram_addr[0] !== AW'(5)) begin failures++; $display("FAIL raw_ram_addr got=%0d want=5", ram_addr[0]); end
      checks++; if (ram_di[0] !== 32'hA5A5) begin failures++; $display("FAIL raw_ram_di got=%0h want=a5a5", ram_di[0]); end
      tick();
      req_we = 1'b0;
      @(negedge clk);
      if (ram_en[0]) en_cnt++;
      checks++; if (ram_we[0] !== 1'b0) begin failures++; $display("FAIL raw_rd_ram_we got=%0b want=0", ram_we[0]); end
      tick();
      req_valid = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         if (ram_en[0]) en_cnt++;
`ifdef BRAM_PORT_MASTER_WRBACK_EN
         want_v = (c == 1) || (c == 2);
`else
         want_v = (c == 2);
`endif
         checks++; if (rsp_valid[0] !== want_v) begin failures++; $display("FAIL raw_rsp_valid_c%0d got=%0b want=%0b", c, rsp_valid[0], want_v); end
         if (c == 2) begin
            checks++; if (rsp_rdata[0] !== 32'hA5A5) begin failures++; $display("FAIL raw_rsp_rdata got=%0h want=a5a5", rsp_rdata[0]); end
         end
         tick();
      end
      checks++; if (en_cnt != 2) begin failures++; $display("FAIL raw_en_cycles got=%0d want=2", en_cnt); end
`ifdef BRAM_PORT_MASTER_WRBACK_EN
      checks++; if (act_q[0].size() != 2) begin failures++; $display("FAIL raw_rsp_count got=%0d want=2", act_q[0].size()); end
`else
      checks++; if (act_q[0].size() != 1) begin failures++; $display("FAIL raw_rsp_count got=%0d want=1", act_q[0].size()); end
`endif
      for (int i = 0; i < act_q[0].size() && i < expd_q[0].size(); i++) begin
         checks++; if (act_q[0][i] !== expd_q[0][i]) begin failures++; $display("FAIL raw_rsp_data[%0d] got=%0h want=%0h", i, act_q[0][i], expd_q[0][i]); end
      end
   endtask

   task automatic test_back_to_back();
      logic want_v;
      preload();
      rsp_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         req_valid = (c < 8);
         req_we    = 1'b0;
         req_addr  = AW'(c % 8);
         @(negedge clk);
         if (c < 8) begin
            checks++; if (req_ready[0] !== 1'b1) begin failures++; $display("FAIL b2b_req_ready_c%0d got=%0b want=1", c, req_ready[0]); end
         end
         want_v = (c >= 2) && (c < 10);
         checks++; if (rsp_valid[0] !== want_v) begin failures++; $display("FAIL b2b_rsp_valid_c%0d got=%0b want=%0b", c, rsp_valid[0], want_v); end
         tick();
      end
      req_valid = 1'b0;
      checks++; if (act_q[0].size() != 8) begin failures++; $display("FAIL b2b_rsp_count got=%0d want=8", act_q[0].size()); end
      for (int i = 0; i < act_q[0].size() && i < expd_q[0].size(); i++) begin
         checks++; if (act_q[0][i] !== expd_q[0][i]) begin failures++; $display("FAIL b2b_rsp_data[%0d] got=%0h want=%0h", i, act_q[0][i], expd_q[0][i]); end
      end
   endtask

   task automatic test_backpressure();
      int acc;
      int acc2;
      logic [WIDTH-1:0] held;
      preload();
      rsp_ready = 1'b0;
      acc = 0; acc2 = 0; held = '0;
      for (int c = 0; c < 8; c++) begin
         req_valid = 1'b1; req_we = 1'b0;
         req_addr = AW'($urandom_range(0, SIZE - 1));
         @(negedge clk);
         if (req_ready[0]) acc++;
         if (c == 2) held = rsp_rdata[0];
         if (c > 2) begin
            checks++; if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== held) begin failures++; $display("FAIL bp_hold_c%0d got=%0b/%0h want=1/%0h", c, rsp_valid[0], rsp_rdata[0], held); end
         end
         tick();
      end
      @(negedge clk);
      checks++; if (req_ready[0] !== 1'b0) begin failures++; $display("FAIL bp_stalled got=%0b want=0", req_ready[0]); end
      checks++; if (acc != 4) begin failures++; $display("FAIL bp_accepted got=%0d want=4", acc); end
      tick();
      rsp_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         req_valid = 1'b1; req_we = 1'b0;
         req_addr = AW'($urandom_range(0, SIZE - 1));
         @(negedge clk);
         if (req_ready[0]) acc2++;
         tick();
      end
      req_valid = 1'b0;
      repeat (8) tick();
      checks++; if (acc2 != 12) begin failures++; $display("FAIL bp_resume_accepted got=%0d want=12", acc2); end
      checks++; if (act_q[0].size() != acc + acc2) begin failures++; $display("FAIL bp_rsp_count got=%0d want=%0d", act_q[0].size(), acc + acc2); end
      checks++; if (unexp[0] != 0) begin failures++; $display("FAIL bp_unexpected got=%0d want=0", unexp[0]); end
      for (int i = 0; i < act_q[0].size() && i < expd_q[0].size(); i++) begin
         checks++; if (act_q[0][i] !== expd_q[0][i]) begin failures++; $display("FAIL bp_rsp_data[%0d] got=%0h want=%0h", i, act_q[0][i], expd_q[0][i]); end
      end
   endtask

   task automatic test_write_burst();
      int acc;
      int seen_v;
      int total;
      preload();
      rsp_ready = 1'b0;
      acc = 0; seen_v = 0;
      for (int c = 0; c < 16; c++) begin
         req_valid = 1'b1; req_we = 1'b1;
         req_addr  = AW'($urandom_range(0, 7));
         req_wdata = WIDTH'($urandom);
         @(negedge clk);
         if (req_ready[0]) acc++;
         if (rsp_valid[0]) seen_v = 1;
         tick();
      end
      req_valid = 1'b0;
      repeat (2) begin
         @(negedge clk);
         if (rsp_valid[0]) seen_v = 1;
         tick();
      end
`ifdef BRAM_PORT_MASTER_WRBACK_EN
      checks++; if (acc != 4) begin failures++; $display("FAIL wr_accepted got=%0d want=4", acc); end
      checks++; if (seen_v != 1) begin failures++; $display("FAIL wr_rsp_seen got=%0d want=1", seen_v); end
`else
      checks++; if (acc != 16) begin failures++; $display("FAIL wr_accepted got=%0d want=16", acc); end
      checks++; if (seen_v != 0) begin failures++; $display("FAIL wr_rsp_seen got=%0d want=0", seen_v); end
`endif
      rsp_ready = 1'b1;
      repeat (6) tick();
      total = 0;
      for (int c = 0; c < 8; c++) begin
         req_valid = 1'b1; req_we = 1'b0;
         req_addr  = AW'(c);
         @(negedge clk);
         if (req_ready[0]) total++;
         tick();
      end
      req_valid = 1'b0;
      repeat (6) tick();
`ifdef BRAM_PORT_MASTER_WRBACK_EN
      total = total + acc;
`endif
      checks++; if (act_q[0].size() != total) begin failures++; $display("FAIL wr_rsp_count got=%0d want=%0d", act_q[0].size(), total); end
      checks++; if (unexp[0] != 0) begin failures++; $display("FAIL wr_unexpected got=%0d want=0", unexp[0]); end
      for (int i = 0; i < act_q[0].size() && i < expd_q[0].size(); i++) begin
         checks++; if (act_q[0][i] !== expd_q[0][i]) begin failures++; $display("FAIL wr_rsp_data[%0d] got=%0h want=%0h", i, act_q[0][i], expd_q[0][i]); end
      end
   endtask

   task automatic test_reset_mid();
      preload();
      rsp_ready = 1'b1;
      req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(9);
      @(negedge clk);
      checks++; if (req_ready[0] !== 1'b1) begin failures++; $display("FAIL rm_issue got=%0b want=1", req_ready[0]); end
      tick();
      req_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++; if (rsp_valid[0] !== 1'b0) begin failures++; $display("FAIL rm_rsp_valid_in_rst got=%0b want=0", rsp_valid[0]); end
      checks++; if (req_ready[0] !== 1'b0) begin failures++; $display("FAIL rm_req_ready_in_rst got=%0b want=0", req_ready[0]); end
      repeat (2) tick();
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checks++; if (rsp_valid[0] !== 1'b0) begin failures++; $display("FAIL rm_rsp_valid_after_c%0d got=%0b want=0", c, rsp_valid[0]); end
         tick();
      end
      req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(12);
      @(negedge clk);
      tick();
      req_valid = 1'b0;
      repeat (4) tick();
      checks++; if (act_q[0].size() != 1) begin failures++; $display("FAIL rm_rsp_count got=%0d want=1", act_q[0].size()); end
      if (act_q[0].size() > 0 && expd_q[0].size() > 0) begin
         checks++; if (act_q[0][0] !== expd_q[0][0]) begin failures++; $display("FAIL rm_rsp_data got=%0h want=%0h", act_q[0][0], expd_q[0][0]); end
      end
   endtask

   task automatic test_wrap();
      int issued;
      int cyc;
      logic hold_prev;
      logic hs;
      logic [WIDTH-1:0] prev_data;
      preload();
      issued = 0; cyc = 0; hold_prev = 1'b0; prev_data = '0;
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_we = 1'b0;
      req_addr = AW'($urandom_range(0, SIZE - 1));
      while ((issued < 10 || act_q[1].size() < 10) && cyc < 300) begin
         @(negedge clk);
         if (hold_prev) begin
            checks++; if (rsp_valid[1] !== 1'b1 || rsp_rdata[1] !== prev_data) begin failures++; $display("FAIL wrap_hold_cyc%0d got=%0b/%0h want=1/%0h", cyc, rsp_valid[1], rsp_rdata[1], prev_data); end
         end
         hold_prev = rsp_valid[1] && !rsp_ready;
         prev_data = rsp_rdata[1];
         hs = req_valid && req_ready[1];
         if (hs) issued++;
         tick();
         cyc++;
         rsp_ready = ~rsp_ready;
         if (hs) req_addr = AW'($urandom_range(0, SIZE - 1));
         if (issued >= 10) req_valid = 1'b0;
      end
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      checks++; if (issued != 10) begin failures++; $display("FAIL wrap_issued got=%0d want=10", issued); end
      checks++; if (act_q[1].size() != 10) begin failures++; $display("FAIL wrap_rsp_count got=%0d want=10", act_q[1].size()); end
      checks++; if (unexp[1] != 0) begin failures++; $display("FAIL wrap_unexpected got=%0d want=0", unexp[1]); end
      for (int i = 0; i < act_q[1].size() && i < expd_q[1].size(); i++) begin
         checks++; if (act_q[1][i] !== expd_q[1][i]) begin failures++; $display("FAIL wrap_rsp_data[%0d] got=%0h want=%0h", i, act_q[1][i], expd_q[1][i]); end
      end
   endtask

   initial begin
      test_reset();
      test_read_after_write();
      test_back_to_back();
      test_backpressure();
      test_write_burst();
      test_reset_mid();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
